imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t     : loader FSM state encoding
//   WORD_STRIDE : byte distance between consecutive instruction words
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_WR0       = 3'd2,
    ST_WR1       = 3'd3,
    ST_WR2       = 3'd4,
    ST_WR3       = 3'd5,
    ST_FINISH    = 3'd6
  } state_t;

  localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Word-stream handshake plus byte-write bus of the instruction-memory loader.
//   WordValid/WordData/WordLast : word source -> loader
//   WordReady                   : loader -> word source
//   MemWrite/MemAddress/MemByte : loader -> instruction memory
// Modports: master = word source / memory side, slave = loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  WordValid;
  logic [31:0]           WordData;
  logic                  WordLast;
  logic                  WordReady;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [7:0]            MemByte;

  modport master (
    output WordValid, WordData, WordLast,
    input  WordReady, MemWrite, MemAddress, MemByte
  );

  modport slave (
    input  WordValid, WordData, WordLast,
    output WordReady, MemWrite, MemAddress, MemByte
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words over a valid/ready stream
// and writes each one as four big-endian bytes to a byte-wide memory.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   Start        : one-cycle session request (honoured only when idle)
//   StartAddress : first byte address of the session (bits [1:0] dropped)
//   bus          : word stream + memory write bus (slave modport)
//   Busy, Done   : session in progress / one-cycle end-of-session pulse
//   Wrapped      : sticky, pointer wrapped past the top address
//   WordCount    : words written this session, saturating
//
// state      | meaning
// IDLE       | no session, waiting for Start
// WAIT_WORD  | WordReady high, waiting for WordValid
// WR0..WR3   | one byte write per state, MSB first
// FINISH     | Done pulse, then back to IDLE
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int COUNT_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [ADDR_WIDTH-1:0]  StartAddress,
  imem_loader_if.slave           bus,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Wrapped,
  output logic [COUNT_WIDTH-1:0] WordCount
);

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_WIDTH-1:0]  r_ptr;
  logic [31:0]            r_word;
  logic                   r_last;
  logic                   r_mem_write;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [7:0]             r_mem_byte;
  logic                   r_wrapped;
  logic [COUNT_WIDTH-1:0] r_count;

  logic                   w_xfer;
  logic                   w_lane_wr;
  logic [1:0]             w_lane;
  logic [31:0]            w_word;
  logic [7:0]             w_byte;
  logic [ADDR_WIDTH:0]    w_ptr_inc;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_xfer = 1'b0;
    case (r_state)
      ST_IDLE:      if (Start) w_next = ST_WAIT_WORD;
      ST_WAIT_WORD: if (bus.WordValid) begin
        w_xfer = 1'b1;
        w_next = ST_WR0;
      end
      ST_WR0:       w_next = ST_WR1;
      ST_WR1:       w_next = ST_WR2;
      ST_WR2:       w_next = ST_WR3;
      ST_WR3:       w_next = r_last ? ST_FINISH : ST_WAIT_WORD;
      ST_FINISH:    w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Memory outputs are registered, so the lane is chosen from the state being
  // entered; on the transfer edge the word has not been captured yet and is
  // taken straight from the bus.
  always_comb begin
    w_lane_wr = 1'b1;
    w_lane    = 2'd0;
    case (w_next)
      ST_WR0:  w_lane = 2'd0;
      ST_WR1:  w_lane = 2'd1;
      ST_WR2:  w_lane = 2'd2;
      ST_WR3:  w_lane = 2'd3;
      default: w_lane_wr = 1'b0;
    endcase
  end

  assign w_word = w_xfer ? bus.WordData : r_word;

  always_comb begin
    w_byte = w_word[31:24];
    case (w_lane)
      2'd0: w_byte = w_word[31:24];
      2'd1: w_byte = w_word[23:16];
      2'd2: w_byte = w_word[15:8];
      2'd3: w_byte = w_word[7:0];
      default: w_byte = w_word[31:24];
    endcase
  end

  // Extra MSB catches the carry out of the top address for Wrapped.
  assign w_ptr_inc = {1'b0, r_ptr} + (ADDR_WIDTH+1)'(WORD_STRIDE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_word      <= '0;
      r_last      <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_byte  <= '0;
      r_wrapped   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_mem_write <= w_lane_wr;
      if (w_lane_wr) begin
        // Pointer is word aligned, so the lane simply fills the low bits.
        r_mem_addr <= {r_ptr[ADDR_WIDTH-1:2], w_lane};
        r_mem_byte <= w_byte;
      end
      if (r_state == ST_IDLE && Start) begin
        r_ptr     <= StartAddress & ~ADDR_WIDTH'(3);
        r_count   <= '0;
        r_wrapped <= 1'b0;
      end
      if (w_xfer) begin
        r_word <= bus.WordData;
        r_last <= bus.WordLast;
      end
      if (r_state == ST_WR3) begin
        r_ptr <= w_ptr_inc[ADDR_WIDTH-1:0];
        if (w_ptr_inc[ADDR_WIDTH]) r_wrapped <= 1'b1;
        if (r_count != '1) r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.WordReady  = (r_state == ST_WAIT_WORD);
  assign bus.MemWrite   = r_mem_write;
  assign bus.MemAddress = r_mem_addr;
  assign bus.MemByte    = r_mem_byte;
  assign Busy           = (r_state != ST_IDLE);
  assign Done           = (r_state == ST_FINISH);
  assign Wrapped        = r_wrapped;
  assign WordCount      = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: a cycle-timeline model predicts every output
// each cycle; a byte array fed from MemWrite acts as the instruction memory
// that loaded words are read back from.
module tb_imem_loader;
  localparam int AW = 10;
  localparam int CW = 9;
  localparam int MEMSZ = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Start = 1'b0;
  logic [AW-1:0] StartAddress = '0;
  logic          Busy, Done, Wrapped;
  logic [CW-1:0] WordCount;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .Start(Start), .StartAddress(StartAddress),
    .bus(bus.slave), .Busy(Busy), .Done(Done), .Wrapped(Wrapped),
    .WordCount(WordCount)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef struct { int t; int a; logic [7:0] b; } wr_t;
  wr_t wq[$];
  logic [7:0] m_img [MEMSZ];
  logic [7:0] dut_img [MEMSZ];
  logic m_ready = 0, m_busy = 0, m_done = 0, m_we = 0, m_wrapped = 0;
  int   m_addr = 0, m_ptr = 0, m_count = 0;
  logic [7:0] m_byte = 0;
  int   t_ready = -1, t_done = -1, t_idle = -1, t_update = -1;

  always @(posedge clk) begin : model
    int e;
    logic start_ok, xfer;
    wr_t w;
    e = cyc + 1;
    if (reset) begin
      wq.delete();
      m_ready = 0; m_busy = 0; m_done = 0; m_we = 0; m_wrapped = 0;
      m_addr = 0; m_byte = 0; m_ptr = 0; m_count = 0;
      t_ready = -1; t_done = -1; t_idle = -1; t_update = -1;
    end else begin
      start_ok = !m_busy && Start;
      xfer = m_ready && bus.WordValid;
      m_done = 0;
      m_we = 0;
      if (start_ok) begin
        m_busy = 1; m_ready = 1; m_count = 0; m_wrapped = 0;
        m_ptr = int'(StartAddress) & ~3;
      end
      if (xfer) begin
        m_ready = 0;
        for (int i = 0; i < 4; i++) begin
          w.t = e + i;
          w.a = (m_ptr + i) % MEMSZ;
          w.b = bus.WordData[31 - 8*i -: 8];
          wq.push_back(w);
        end
        t_update = e + 4;
        if (bus.WordLast) begin t_done = e + 4; t_idle = e + 5; end
        else t_ready = e + 4;
      end
      if (wq.size() > 0 && wq[0].t == e) begin
        w = wq.pop_front();
        m_we = 1; m_addr = w.a; m_byte = w.b;
        m_img[w.a] = w.b;
      end
      if (e == t_update) begin
        if (m_ptr + 4 >= MEMSZ) m_wrapped = 1;
        m_ptr = (m_ptr + 4) % MEMSZ;
        if (m_count < CMAX) m_count++;
      end
      if (e == t_ready) m_ready = 1;
      if (e == t_done)  m_done = 1;
      if (e == t_idle)  m_busy = 0;
    end
    cyc = e;
  end

  int last_done = -1;
  always @(negedge clk) begin : compare
    if (cyc > 0) begin
      chk("WordReady", 32'(bus.WordReady), 32'(m_ready));
      chk("MemWrite", 32'(bus.MemWrite), 32'(m_we));
      chk("MemAddress", 32'(bus.MemAddress), m_addr);
      chk("MemByte", 32'(bus.MemByte), 32'(m_byte));
      chk("Busy", 32'(Busy), 32'(m_busy));
      chk("Done", 32'(Done), 32'(m_done));
      chk("Wrapped", 32'(Wrapped), 32'(m_wrapped));
      chk("WordCount", 32'(WordCount), m_count);
      if (bus.MemWrite) dut_img[bus.MemAddress] = bus.MemByte;
      if (Done) last_done = cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [AW-1:0] a);
    Start = 1'b1;
    StartAddress = a;
    tick();
    Start = 1'b0;
    StartAddress = AW'($urandom);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, output int xcyc);
    int n = 0;
    bus.WordValid = 1'b1;
    bus.WordData = d;
    bus.WordLast = last;
    while (!bus.WordReady && n < 40) begin tick(); n++; end
    if (!bus.WordReady) begin
      vectors++; miscompares++;
      $display("FAIL word_handshake_timeout cycle %0d: got no WordReady expected WordReady", cyc);
    end
    xcyc = cyc;
    tick();
    bus.WordValid = 1'b0;
    bus.WordData = $urandom;
    bus.WordLast = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 40) begin tick(); n++; end
    if (Busy) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout cycle %0d: got Busy=1 expected Busy=0", cyc);
    end
    tick();
  endtask

  function automatic logic [31:0] rd_word(input int a);
    return {dut_img[a], dut_img[(a+1)%MEMSZ], dut_img[(a+2)%MEMSZ], dut_img[(a+3)%MEMSZ]};
  endfunction

  initial begin
    int x0, x1, x2, wcnt;
    for (int i = 0; i < MEMSZ; i++) begin dut_img[i] = 8'h00; m_img[i] = 8'h00; end
    bus.WordValid = 1'b0;
    bus.WordData = '0;
    bus.WordLast = 1'b0;
    repeat (3) tick();
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_count", 32'(WordCount), 32'd0);
    reset = 1'b0;
    tick();

    // single word at address 0
    start_session(10'h000);
    send_word(32'h8C220004, 1'b1, x0);
    wait_idle();
    chk("single_word", rd_word(0), 32'h8C220004);
    chk("single_done_latency", 32'(last_done - x0), 32'd5);
    chk("single_count", 32'(WordCount), 32'd1);

    // unaligned start, back-to-back words
    start_session(10'h013);
    send_word(32'h11223344, 1'b0, x0);
    send_word(32'h55667788, 1'b0, x1);
    send_word(32'h99AABBCC, 1'b1, x2);
    wait_idle();
    chk("b2b_w0", rd_word(10'h010), 32'h11223344);
    chk("b2b_w1", rd_word(10'h014), 32'h55667788);
    chk("b2b_w2", rd_word(10'h018), 32'h99AABBCC);
    chk("b2b_gap01", 32'(x1 - x0), 32'd5);
    chk("b2b_gap12", 32'(x2 - x1), 32'd5);
    chk("b2b_count", 32'(WordCount), 32'd3);

    // wrap past the top address
    start_session(10'h3FC);
    send_word(32'hDEADBEEF, 1'b0, x0);
    send_word(32'hCAFEF00D, 1'b1, x1);
    wait_idle();
    chk("wrap_top", rd_word(10'h3FC), 32'hDEADBEEF);
    chk("wrap_bottom", rd_word(0), 32'hCAFEF00D);
    chk("wrap_flag", 32'(Wrapped), 32'd1);

    // next Start clears Wrapped; then a 10-cycle stall
    start_session(10'h100);
    chk("wrap_cleared", 32'(Wrapped), 32'd0);
    wcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.MemWrite) wcnt++;
      if (!bus.WordReady) wcnt++;
      tick();
    end
    chk("stall_activity", 32'(wcnt), 32'd0);
    send_word(32'h01020304, 1'b1, x0);
    wait_idle();
    chk("stall_word", rd_word(10'h100), 32'h01020304);

    // Start pulsed while busy is ignored
    start_session(10'h200);
    send_word(32'hA1B2C3D4, 1'b0, x0);
    Start = 1'b1;
    StartAddress = 10'h000;
    tick();
    Start = 1'b0;
    send_word(32'hE5F60718, 1'b1, x1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    wait_idle();
    chk("busy_start_w0", rd_word(10'h200), 32'hA1B2C3D4);
    chk("busy_start_w1", rd_word(10'h204), 32'hE5F60718);
    chk("busy_start_lo", rd_word(0), 32'hCAFEF00D);

    // reset in WR1 aborts the word
    start_session(10'h080);
    send_word(32'h0BADF00D, 1'b0, x0);
    tick();
    reset = 1'b1;
    tick();
    chk("abort_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    reset = 1'b0;
    tick();
    chk("abort_still_idle", 32'(bus.MemWrite), 32'd0);
    start_session(10'h084);
    send_word(32'h13572468, 1'b1, x0);
    wait_idle();
    chk("after_abort_word", rd_word(10'h084), 32'h13572468);
    chk("after_abort_count", 32'(WordCount), 32'd1);

    // long session: count saturation and wrap
    start_session(10'h000);
    for (int i = 0; i < 515; i++) begin
      send_word((32'(i) * 32'h01010101) ^ 32'hA5000000, i == 514, x0);
    end
    wait_idle();
    chk("sat_count", 32'(WordCount), 32'd511);
    chk("sat_wrapped", 32'(Wrapped), 32'd1);
    chk("sat_last_word", rd_word((514 * 4) % MEMSZ), (32'd514 * 32'h01010101) ^ 32'hA5000000);

    for (int i = 0; i < MEMSZ; i++) chk("image", 32'(dut_img[i]), 32'(m_img[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
